// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle for mod_counter
interface mod_counter_if #(parameter int WIDTH = 2);
  logic             start, stop, oneshot, en, up_dn, load;
  logic [WIDTH-1:0] load_val, count;
  logic             tc, wrap, busy, done;
  modport master (output start, stop, oneshot, en, up_dn, load, load_val,
                  input count, tc, wrap, busy, done);
  modport slave (input start, stop, oneshot, en, up_dn, load, load_val,
                 output count, tc, wrap, busy, done);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD up/down counter with run/stop/one-shot control.
// Defining COUNTER_SAT_EN makes steps saturate at the boundaries instead of wrapping.
module mod_counter #(
  parameter int WIDTH     = 2,
  parameter int MOD       = 4,
  parameter int RESET_VAL = 0
) (
  input logic clk,
  input logic rst,
  mod_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, count_step, load_sat;
  logic             wrap_q, wrap_d, oneshot_q, oneshot_d, step, bnd, wrap_ev;
  always_comb begin
    step     = state_q == RUN && bus.en && !bus.load;
    bnd      = bus.up_dn ? count_q == MAX : count_q == '0;
    wrap_ev  = step && bnd;
    load_sat = ({1'b0, bus.load_val} >= MOD_W) ? MAX : bus.load_val;
`ifdef COUNTER_SAT_EN
    count_step = bnd ? count_q : (bus.up_dn ? count_q + 1'b1 : count_q - 1'b1);
    wrap_d     = 1'b0;
`else
    count_step = bnd ? (bus.up_dn ? '0 : MAX) : (bus.up_dn ? count_q + 1'b1 : count_q - 1'b1);
    wrap_d     = wrap_ev;
`endif
    count_d   = bus.load ? load_sat : step ? count_step : count_q;
    // stop has priority over a one-shot boundary event
    state_d   = (state_q == RUN) ? (bus.stop ? IDLE : (wrap_ev && oneshot_q) ? DONE : RUN)
                                 : (bus.start ? RUN : state_q);
    oneshot_d = (state_q != RUN && bus.start) ? bus.oneshot : oneshot_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= WIDTH'(RESET_VAL);
      wrap_q    <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      oneshot_q <= oneshot_d;
    end
  end
  assign bus.count = count_q;
  assign bus.tc    = bus.up_dn ? count_q == MAX : count_q == '0;
  assign bus.wrap  = wrap_q;
  assign bus.busy  = state_q == RUN;
  assign bus.done  = state_q == DONE;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed scoreboard bench for a MOD=4 and a MOD=10 instance.
module tb_mod_counter;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    string name;
    bit    sel;
    int    count;
    bit    wrap, busy, done, tc;
  } exp_t;
  logic clk = 1'b0, rst;
  exp_t sb[$];
  int   checks = 0, errors = 0;
  bit   finished = 1'b0;
  mod_counter_if #(.WIDTH(2)) b4 ();
  mod_counter_if #(.WIDTH(4)) b10 ();
  mod_counter #(.WIDTH(2), .MOD(4), .RESET_VAL(0)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mod_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(2)) u10 (.clk(clk), .rst(rst), .bus(b10));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   c;
      bit   w, b, d, t;
      e = sb.pop_front();
      c = e.sel ? int'(b10.count) : int'(b4.count);
      w = e.sel ? b10.wrap : b4.wrap;
      b = e.sel ? b10.busy : b4.busy;
      d = e.sel ? b10.done : b4.done;
      t = e.sel ? b10.tc : b4.tc;
      checks++;
      if (c != e.count || w != e.wrap || b != e.busy || d != e.done || t != e.tc) begin
        errors++;
        $display("FAIL %s: got count=%0d wrap=%0b busy=%0b done=%0b tc=%0b, want count=%0d wrap=%0b busy=%0b done=%0b tc=%0b",
                 e.name, c, w, b, d, t, e.count, e.wrap, e.busy, e.done, e.tc);
      end
    end
  end
  initial begin
    #100000;
    if (!finished) begin
      errors++;
      $display("FAIL timeout: test did not complete in time");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end
  function automatic void push(string n, bit s, int c, bit w, bit b, bit d, bit t);
    exp_t e;
    e.name = n; e.sel = s; e.count = c; e.wrap = w; e.busy = b; e.done = d; e.tc = t;
    sb.push_back(e);
  endfunction
  task automatic tick(string n, bit s, int c, bit w, bit b, bit d, bit t);
    @(posedge clk);
    push(n, s, c, w, b, d, t);
    @(negedge clk);
    #1;
  endtask
  task automatic idle();
    {b4.start, b4.stop, b4.oneshot, b4.en, b4.load} = '0;
    {b10.start, b10.stop, b10.oneshot, b10.en, b10.load} = '0;
    b4.up_dn = 1'b1; b10.up_dn = 1'b1;
    b4.load_val = '0; b10.load_val = '0;
  endtask
  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    push("rst_m4", 0, 0, 0, 0, 0, 0);
    push("rst_m10", 1, 2, 0, 0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if (b4.busy || b4.done || b4.wrap || b4.count != 2'd0 ||
        b10.busy || b10.done || b10.wrap || b10.count != 4'd2) begin
      errors++;
      $display("FAIL reset_state: m4 count=%0d busy=%0b done=%0b wrap=%0b m10 count=%0d busy=%0b done=%0b wrap=%0b",
               b4.count, b4.busy, b4.done, b4.wrap, b10.count, b10.busy, b10.done, b10.wrap);
    end
    rst = 1'b0;
    b4.start = 1'b1;
    tick("t1_start", 0, 0, 0, 1, 0, 0);
    b4.start = 1'b0; b4.en = 1'b1;
    tick("t1_s1", 0, 1, 0, 1, 0, 0);
    tick("t1_s2", 0, 2, 0, 1, 0, 0);
    tick("t1_s3", 0, 3, 0, 1, 0, 1);
    tick("t1_wrap", 0, SAT ? 3 : 0, !SAT, 1, 0, SAT);
    tick("t1_s5", 0, SAT ? 3 : 1, 0, 1, 0, SAT);
    b4.en = 1'b0; b4.stop = 1'b1;
    tick("t1_stop", 0, SAT ? 3 : 1, 0, 0, 0, SAT);
    b4.stop = 1'b0;
    b10.load = 1'b1; b10.load_val = 4'd9; b10.start = 1'b1;
    tick("t2_load_start", 1, 9, 0, 1, 0, 1);
    b10.load = 1'b0; b10.start = 1'b0; b10.en = 1'b1;
    tick("t2_up_wrap", 1, SAT ? 9 : 0, !SAT, 1, 0, SAT);
    b10.en = 1'b0; b10.load = 1'b1; b10.load_val = 4'd0; b10.up_dn = 1'b0;
    tick("t2_load0", 1, 0, 0, 1, 0, 1);
    b10.load = 1'b0; b10.en = 1'b1;
    tick("t2_dn_wrap", 1, SAT ? 0 : 9, !SAT, 1, 0, SAT);
    b10.en = 1'b0;
    tick("t2_hold", 1, SAT ? 0 : 9, 0, 1, 0, SAT);
    b10.load = 1'b1; b10.load_val = 4'd12;
    tick("t4_clamp", 1, 9, 0, 1, 0, 0);
    b10.load_val = 4'd5;
    tick("t4_load5", 1, 5, 0, 1, 0, 0);
    b10.load_val = 4'd3; b10.en = 1'b1;
    tick("t4_load_en", 1, 3, 0, 1, 0, 0);
    b10.load = 1'b0;
    tick("t4_dn_step", 1, 2, 0, 1, 0, 0);
    b10.en = 1'b0; b10.load = 1'b1; b10.load_val = 4'd7;
    tick("t5_load7", 1, 7, 0, 1, 0, 0);
    b10.load = 1'b0; b10.en = 1'b1; b10.start = 1'b1; rst = 1'b1;
    @(posedge clk);
    push("t5_rst_m10", 1, 2, 0, 0, 0, 0);
    push("t5_rst_m4", 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    rst = 1'b0; idle();
    b4.load = 1'b1; b4.load_val = 2'd2;
    tick("t3_load2", 0, 2, 0, 0, 0, 0);
    b4.load = 1'b0; b4.start = 1'b1; b4.oneshot = 1'b1;
    tick("t3_start", 0, 2, 0, 1, 0, 0);
    b4.start = 1'b0; b4.oneshot = 1'b0; b4.en = 1'b1;
    tick("t3_s3", 0, 3, 0, 1, 0, 1);
    tick("t3_done", 0, SAT ? 3 : 0, !SAT, 0, 1, SAT);
    tick("t3_hold", 0, SAT ? 3 : 0, 0, 0, 1, SAT);
    b4.en = 1'b0; b4.start = 1'b1; b4.oneshot = 1'b1;
    tick("t3_restart", 0, SAT ? 3 : 0, 0, 1, 0, SAT);
    b4.start = 1'b0; b4.oneshot = 1'b0; b4.en = 1'b1; b4.up_dn = 1'b0; b4.stop = 1'b1;
    tick("stop_beats_wrap", 0, SAT ? 2 : 3, !SAT, 0, 0, 0);
    b4.stop = 1'b0;
    tick("idle_en_ignored", 0, SAT ? 2 : 3, 0, 0, 0, 0);
    b4.up_dn = 1'b1;
    tick("tc_follows_dir", 0, SAT ? 2 : 3, 0, 0, 0, !SAT);
    @(negedge clk); #1;
    finished = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
